// File: rtl/mem_access_unit.sv
// mem_access_unit: RISC-V load/store front-end to a word-addressed memory, with
// lane extraction, sign/zero extension, sub-word read-modify-write and request checking.
module mem_access_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_DONE} state_t;
    localparam logic [29:0] LP_LIMIT = 30'(MEM_WORDS);

    state_t      r_state, w_next;
    logic        r_we, r_err;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_rdata, r_merge;
    logic        w_bad, w_sub_store;
    logic [4:0]  w_sh;
    logic [31:0] w_lane, w_load, w_mask, w_merged;

    assign w_bad = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) | (we & funct3[2])
                 | ((funct3[1:0] == 2'b01) & addr[0]) | ((funct3[1:0] == 2'b10) & |addr[1:0])
                 | (addr[31:2] >= LP_LIMIT);
    assign w_sub_store = r_we & ~r_funct3[1];
    assign w_sh        = {r_addr[1:0], 3'b000};
    assign w_lane      = mem_read_data >> w_sh;
    // funct3[2] selects zero extension; funct3[1:0] selects the access size
    assign w_load   = r_funct3[1] ? mem_read_data
                    : r_funct3[0] ? {{16{~r_funct3[2] & w_lane[15]}}, w_lane[15:0]}
                    : {{24{~r_funct3[2] & w_lane[7]}}, w_lane[7:0]};
    assign w_mask   = r_funct3[0] ? (32'h0000FFFF << w_sh) : (32'h000000FF << w_sh);
    assign w_merged = (mem_read_data & ~w_mask) | ((r_wdata << w_sh) & w_mask);
    assign rdata    = r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = req ? (w_bad ? S_DONE : S_ACCESS) : S_IDLE;
            S_ACCESS: w_next = w_sub_store ? S_WRITE : S_DONE;
            S_WRITE:  w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = r_state != S_IDLE;
        done           = r_state == S_DONE;
        err            = done & r_err;
        mem_address    = (r_state == S_ACCESS || r_state == S_WRITE) ? {r_addr[31:2], 2'b00} : 32'd0;
        mem_write      = (r_state == S_WRITE) | ((r_state == S_ACCESS) & r_we & r_funct3[1]);
        mem_write_data = (r_state == S_WRITE) ? r_merge : r_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_merge  <= 32'd0;
        end else if (r_state == S_IDLE && req) begin
            r_we     <= we;
            r_err    <= w_bad;
            r_funct3 <= funct3;
            r_addr   <= addr;
            r_wdata  <= wdata;
            r_rdata  <= 32'd0;
        end else if (r_state == S_ACCESS) begin
            if (!r_we) r_rdata <= w_load;
            if (w_sub_store) r_merge <= w_merged;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed tests of loads, stores, rejected requests,
// mid-operation reset and requests issued while busy.
module tb_mem_access_unit;
    logic        clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        busy, done, err, mem_write;
    logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [31:0] pl_val = 32'd0;
    int          wr_cnt = 0, done_cnt = 0;
    int          total = 0, bad = 0;
    int          lat, writes;
    logic        got_err;
    logic [31:0] got_rdata;

    mem_access_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = (mem_address[31:10] == 22'd0) ? mem[mem_address[9:2]] : 32'd0;

    always @(posedge clk) begin
        if (pl_en) mem[4] <= pl_val;
        else if (mem_write && mem_address[31:10] == 22'd0) mem[mem_address[9:2]] <= mem_write_data;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic preload(input logic [31:0] v);
        @(negedge clk); pl_en = 1'b1; pl_val = v;
        @(negedge clk); pl_en = 1'b0;
    endtask

    task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int w0;
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d; w0 = wr_cnt;
        @(posedge clk); #1 req = 1'b0;
        lat = 1;
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        got_err = err; got_rdata = rdata;
        @(posedge clk); #1;
        writes = wr_cnt - w0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
        total++; if (mem_address !== 32'd0) begin bad++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_loads;
        logic [2:0]  f [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [31:0] a [5] = '{32'h11, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] e [5] = '{32'hFFFFFFAA, 32'h00000088, 32'h00008899, 32'hFFFFAABB, 32'h8899AABB};
        preload(32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            run(1'b0, f[i], a[i], 32'hFFFFFFFF);
            total++; if (got_rdata !== e[i]) begin bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, got_rdata, e[i]); end
            total++; if (got_err !== 1'b0) begin bad++; $display("FAIL load%0d_err got=%b exp=0", i, got_err); end
            total++; if (lat !== 2) begin bad++; $display("FAIL load%0d_latency got=%0d exp=2", i, lat); end
            total++; if (writes !== 0) begin bad++; $display("FAIL load%0d_writes got=%0d exp=0", i, writes); end
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] a [3] = '{32'h12, 32'h11, 32'h10};
        logic [31:0] d [3] = '{32'hDEAD1234, 32'h00000055, 32'hCAFEF00D};
        logic [31:0] e [3] = '{32'h1234AABB, 32'h889955BB, 32'hCAFEF00D};
        int          l [3] = '{3, 3, 2};
        for (int i = 0; i < 3; i++) begin
            preload(32'h8899AABB);
            run(1'b1, f[i], a[i], d[i]);
            total++; if (mem[4] !== e[i]) begin bad++; $display("FAIL store%0d_word got=%h exp=%h", i, mem[4], e[i]); end
            total++; if (got_err !== 1'b0) begin bad++; $display("FAIL store%0d_err got=%b exp=0", i, got_err); end
            total++; if (lat !== l[i]) begin bad++; $display("FAIL store%0d_latency got=%0d exp=%0d", i, lat, l[i]); end
            total++; if (writes !== 1) begin bad++; $display("FAIL store%0d_writes got=%0d exp=1", i, writes); end
        end
    endtask

    task automatic test_errors;
        logic        w [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
        logic [31:0] a [5] = '{32'h12, 32'h13, 32'h10, 32'h400, 32'h10};
        preload(32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            run(1'b0, 3'b010, 32'h10, 32'd0);
            run(w[i], f[i], a[i], 32'h11223344);
            total++; if (got_err !== 1'b1) begin bad++; $display("FAIL err%0d_err got=%b exp=1", i, got_err); end
            total++; if (got_rdata !== 32'd0) begin bad++; $display("FAIL err%0d_rdata got=%h exp=0", i, got_rdata); end
            total++; if (lat !== 1) begin bad++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
            total++; if (writes !== 0) begin bad++; $display("FAIL err%0d_writes got=%0d exp=0", i, writes); end
            total++; if (mem[4] !== 32'h8899AABB) begin bad++; $display("FAIL err%0d_word got=%h exp=8899aabb", i, mem[4]); end
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        preload(32'h8899AABB);
        d0 = done_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h11; wdata = 32'h55;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL mid_write_state got=%b exp=1", mem_write); end
        reset = 1'b1;
        #1;
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL mid_mem_write got=%b exp=0", mem_write); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (mem[4] !== 32'h8899AABB) begin bad++; $display("FAIL mid_word got=%h exp=8899aabb", mem[4]); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL mid_done_count got=%0d exp=%0d", done_cnt, d0); end
    endtask

    task automatic test_busy_ignore;
        int d0, w0;
        preload(32'h8899AABB);
        d0 = done_cnt; w0 = wr_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'd0;
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h14;
        @(posedge clk); #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_done got=%b exp=1", done); end
        @(posedge clk); #1 req = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b exp=0", busy); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt - d0); end
        total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL busy_writes got=%0d exp=0", wr_cnt - w0); end
        total++; if (rdata !== 32'h8899AABB) begin bad++; $display("FAIL busy_rdata got=%h exp=8899aabb", rdata); end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_errors;
        test_reset_mid;
        test_busy_ignore;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
